eflags_wb: RTL and testbench
============================

EFLAGS_WB -- requirements
Module: eflags_wb

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 ex_valid  in  1  EX stage presents a valid ALU1 result this cycle.
REQ-004 ex_ready  out  1  WB latch can accept the EX result this cycle.
REQ-005 alu_res1  in  32  ALU1 result.
REQ-006 alu1_flags  in  6  ALU1 flags, index order {OF,SF,ZF,AF,PF,CF} = bits [5:0].
REQ-007 cmps_flags  in  6  CMPS flags, same index order.
REQ-008 cmps_sel  in  1  1 selects cmps_flags, 0 selects alu1_flags.
REQ-009 ld_flag_CF, ld_flag_PF, ld_flag_AF, ld_flag_ZF, ld_flag_SF, ld_flag_OF  in  1 each  per-flag load enables.
REQ-010 ld_df  in  1  load DF from df_val_ex.
REQ-011 df_val_ex  in  1  new DF value.
REQ-012 wb_stall  in  1  downstream holds the WB entry.
REQ-013 flush  in  1  discard the WB entry and block capture this cycle.
REQ-014 wb_valid  out  1  WB entry valid.
REQ-015 wb_res  out  32  latched alu_res1.
REQ-016 eflags  out  32  architectural EFLAGS.
REQ-017 CF_fwd, AF_fwd, DF_fwd  out  1 each  forwarded CF_in, AF_in and DF_in to ALU1.
REQ-018 retire_cnt  out  16  count of committed entries.

Function
REQ-019 EFLAGS bit map: CF=0, PF=2, AF=4, ZF=6, SF=7, DF=10, OF=11, bit1 constant 1, all other bits constant 0.
REQ-020 ex_ready SHALL be combinational: ex_ready = !flush && (!wb_valid || !wb_stall).
REQ-021 Capture condition: ex_valid && ex_ready; at the next edge the WB latch SHALL hold alu_res1, the selected 6-bit flag vector, the six ld_flag_* bits, ld_df and df_val_ex, and wb_valid SHALL be 1.
REQ-022 Commit condition: wb_valid && !wb_stall && !flush; at the next edge EFLAGS SHALL be updated, retire_cnt SHALL increment by 1, and the commit SHALL occur in the same edge as any capture.
REQ-023 On commit, each EFLAGS flag SHALL be replaced by the latched flag only where its latched ld bit is 1; DF SHALL be replaced by latched df_val_ex only when latched ld_df is 1.
REQ-024 On commit with no capture in the same cycle, wb_valid SHALL clear at the next edge.
REQ-025 When wb_valid && wb_stall && !flush, the latch and wb_valid SHALL hold, and EFLAGS and retire_cnt SHALL be unchanged.
REQ-026 Flush SHALL set wb_valid to 0 at the next edge, discard the entry without updating EFLAGS, and leave retire_cnt unchanged; flush SHALL override wb_stall and ex_valid.
REQ-027 Forwarding (combinational):
- CF_fwd = latched CF when wb_valid && latched ld_flag_CF, else eflags[0].
- AF_fwd uses ld_flag_AF and eflags[4] in the same way.
- DF_fwd uses ld_df and eflags[10] in the same way.
REQ-028 Forwarding SHALL ignore wb_stall and flush.
REQ-029 retire_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 wb_res SHALL hold its last value when wb_valid = 0.
REQ-031 There SHALL be no combinational path from ex_valid to ex_ready.

Reset
REQ-032 While rst = 1, the block SHALL hold eflags = 32'h0000_0002, wb_valid = 0, wb_res = 0, the latched flags and ld bits = 0, and retire_cnt = 0, independent of clk.
REQ-033 Reset asserted mid-operation SHALL drop the pending WB entry without a commit.
REQ-034 The first capture SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-035 After reset, drive ex_valid=1, alu1_flags=6'b001001 (ZF,CF), all ld_flag_*=1, cmps_sel=0, no stall; two edges later, eflags = 32'h0000_0043 and retire_cnt = 1.
REQ-036 Drive an entry with cmps_sel=1, cmps_flags=6'b010000 (SF), alu1_flags=6'b111111, only ld_flag_SF=1; after commit, only eflags[7] changes, to 1.
REQ-037 Hold wb_stall=1 for 3 cycles with a valid entry and ex_valid=1; ex_ready=0, eflags and retire_cnt are unchanged, and the entry commits on the edge after the stall releases.
REQ-038 Latch an entry with ld_flag_CF=1, CF=1, while eflags[0]=0; CF_fwd=1 in the same cycle, before commit.
REQ-039 Assert flush together with a valid WB entry and ex_valid=1; next cycle wb_valid=0, eflags and retire_cnt are unchanged, and no capture occurs.
REQ-040 Preload retire_cnt to 16'hFFFF via 65535 commits, then commit once more; retire_cnt = 16'h0000.

Source files
------------

// File: rtl/eflags_wb_if.sv
// eflags_wb_if: groups the EX->WB handshake, WB entry, EFLAGS and forwarding
// signals of the EFLAGS write-back stage.
// master = EX/control side driving the stage, slave = eflags_wb itself.
interface eflags_wb_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_res1;
    logic [5:0]  alu1_flags;
    logic [5:0]  cmps_flags;
    logic        cmps_sel;
    logic        ld_flag_CF;
    logic        ld_flag_PF;
    logic        ld_flag_AF;
    logic        ld_flag_ZF;
    logic        ld_flag_SF;
    logic        ld_flag_OF;
    logic        ld_df;
    logic        df_val_ex;
    logic        wb_stall;
    logic        flush;
    logic        wb_valid;
    logic [31:0] wb_res;
    logic [31:0] eflags;
    logic        CF_fwd;
    logic        AF_fwd;
    logic        DF_fwd;
    logic [15:0] retire_cnt;

    modport master (
        output ex_valid, alu_res1, alu1_flags, cmps_flags, cmps_sel,
               ld_flag_CF, ld_flag_PF, ld_flag_AF, ld_flag_ZF, ld_flag_SF, ld_flag_OF,
               ld_df, df_val_ex, wb_stall, flush,
        input  ex_ready, wb_valid, wb_res, eflags, CF_fwd, AF_fwd, DF_fwd, retire_cnt
    );

    modport slave (
        input  ex_valid, alu_res1, alu1_flags, cmps_flags, cmps_sel,
               ld_flag_CF, ld_flag_PF, ld_flag_AF, ld_flag_ZF, ld_flag_SF, ld_flag_OF,
               ld_df, df_val_ex, wb_stall, flush,
        output ex_ready, wb_valid, wb_res, eflags, CF_fwd, AF_fwd, DF_fwd, retire_cnt
    );
endinterface

// File: rtl/eflags_wb.sv
// eflags_wb: single-entry WB latch for ALU1 results that commits per-flag
// updates into architectural EFLAGS and forwards CF/AF/DF back to ALU1.
// Ports: clk, rst (async, active-high), bus (eflags_wb_if.slave).
// Latency: capture on one edge, commit on the next unstalled edge; a commit
// and a new capture may share an edge, giving one entry per cycle.
// Backpressure: ex_ready drops while the entry is stalled or on flush.
module eflags_wb (
    input  logic          clk,
    input  logic          rst,
    eflags_wb_if.slave    bus
);

    // Flag vectors use the order {OF,SF,ZF,AF,PF,CF} = [5:0].
    localparam int CF_I = 0;
    localparam int PF_I = 1;
    localparam int AF_I = 2;
    localparam int ZF_I = 3;
    localparam int SF_I = 4;
    localparam int OF_I = 5;

    logic [31:0] lat_res;
    logic [5:0]  lat_flags;
    logic [5:0]  lat_ld;
    logic        lat_ld_df;
    logic        lat_df;
    logic        wb_valid;
    logic [5:0]  arch_flags;
    logic        arch_df;
    logic [15:0] retire_cnt;

    logic        ex_ready;
    logic        capture;
    logic        commit;
    logic [5:0]  sel_flags;
    logic [5:0]  ld_vec;

    // ex_ready depends only on flush, stall and the held entry, never on
    // ex_valid, so EX may compute ex_valid from ex_ready without a loop.
    assign ex_ready  = !bus.flush && (!wb_valid || !bus.wb_stall);
    assign capture   = bus.ex_valid && ex_ready;
    assign commit    = wb_valid && !bus.wb_stall && !bus.flush;
    assign sel_flags = bus.cmps_sel ? bus.cmps_flags : bus.alu1_flags;
    assign ld_vec    = {bus.ld_flag_OF, bus.ld_flag_SF, bus.ld_flag_ZF,
                        bus.ld_flag_AF, bus.ld_flag_PF, bus.ld_flag_CF};

    // WB latch. Data fields only move on capture, so wb_res keeps its last
    // value once the entry retires or is flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_res   <= 32'h0;
            lat_flags <= 6'h0;
            lat_ld    <= 6'h0;
            lat_ld_df <= 1'b0;
            lat_df    <= 1'b0;
        end else if (capture) begin
            lat_res   <= bus.alu_res1;
            lat_flags <= sel_flags;
            lat_ld    <= ld_vec;
            lat_ld_df <= bus.ld_df;
            lat_df    <= bus.df_val_ex;
        end
    end

    // Flush wins over everything; a capture refills the slot even when the
    // current entry commits on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
        end else if (bus.flush) begin
            wb_valid <= 1'b0;
        end else if (capture) begin
            wb_valid <= 1'b1;
        end else if (commit) begin
            wb_valid <= 1'b0;
        end
    end

    // Architectural state: only flags whose latched load bit is set change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arch_flags <= 6'h0;
            arch_df    <= 1'b0;
            retire_cnt <= 16'h0;
        end else if (commit) begin
            arch_flags <= (arch_flags & ~lat_ld) | (lat_flags & lat_ld);
            if (lat_ld_df) begin
                arch_df <= lat_df;
            end
            retire_cnt <= retire_cnt + 16'd1;
        end
    end

    assign bus.ex_ready   = ex_ready;
    assign bus.wb_valid   = wb_valid;
    assign bus.wb_res     = lat_res;
    assign bus.retire_cnt = retire_cnt;

    // bit1 is reserved-as-one; all unlisted bits read zero.
    assign bus.eflags = {20'h0,
                         arch_flags[OF_I], arch_df, 2'b00,
                         arch_flags[SF_I], arch_flags[ZF_I], 1'b0,
                         arch_flags[AF_I], 1'b0,
                         arch_flags[PF_I], 1'b1,
                         arch_flags[CF_I]};

    // Forwarding looks only at the held entry, not at stall/flush: the
    // entry is the youngest flag producer until it is gone.
    assign bus.CF_fwd = (wb_valid && lat_ld[CF_I]) ? lat_flags[CF_I] : arch_flags[CF_I];
    assign bus.AF_fwd = (wb_valid && lat_ld[AF_I]) ? lat_flags[AF_I] : arch_flags[AF_I];
    assign bus.DF_fwd = (wb_valid && lat_ld_df)    ? lat_df          : arch_df;

endmodule

// File: tb/tb_eflags_wb.sv
// tb_eflags_wb: directed test of eflags_wb with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at the same point, i.e. after the edge has settled.
module tb_eflags_wb;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    eflags_wb_if bus ();

    eflags_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load enables in {OF,SF,ZF,AF,PF,CF} order.
    task automatic set_ld(input logic [5:0] v);
        bus.ld_flag_CF = v[0];
        bus.ld_flag_PF = v[1];
        bus.ld_flag_AF = v[2];
        bus.ld_flag_ZF = v[3];
        bus.ld_flag_SF = v[4];
        bus.ld_flag_OF = v[5];
    endtask

    task automatic idle_inputs();
        bus.ex_valid   = 1'b0;
        bus.alu_res1   = 32'h0;
        bus.alu1_flags = 6'h0;
        bus.cmps_flags = 6'h0;
        bus.cmps_sel   = 1'b0;
        set_ld(6'h0);
        bus.ld_df      = 1'b0;
        bus.df_val_ex  = 1'b0;
        bus.wb_stall   = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        n_cmp++; if (bus.eflags !== 32'h0000_0002) begin $display("FAIL reset_eflags got %h want %h", bus.eflags, 32'h2); n_fail++; end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); n_fail++; end
        n_cmp++; if (bus.wb_res !== 32'h0) begin $display("FAIL reset_wb_res got %h want 0", bus.wb_res); n_fail++; end
        n_cmp++; if (bus.retire_cnt !== 16'h0) begin $display("FAIL reset_retire got %h want 0", bus.retire_cnt); n_fail++; end
        n_cmp++; if (bus.ex_ready !== 1'b1) begin $display("FAIL reset_ex_ready got %b want 1", bus.ex_ready); n_fail++; end
        n_cmp++; if ({bus.CF_fwd, bus.AF_fwd, bus.DF_fwd} !== 3'b000) begin $display("FAIL reset_fwd got %b want 000", {bus.CF_fwd, bus.AF_fwd, bus.DF_fwd}); n_fail++; end
        // ex_valid during reset must not capture anything.
        bus.ex_valid = 1'b1;
        bus.alu_res1 = 32'hDEAD_BEEF;
        tick();
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b0) begin $display("FAIL reset_hold_valid got %b want 0", bus.wb_valid); n_fail++; end
        n_cmp++; if (bus.wb_res !== 32'h0) begin $display("FAIL reset_hold_res got %h want 0", bus.wb_res); n_fail++; end
        idle_inputs();
        rst = 1'b0;
    endtask

    // ZF+CF through ALU1 path with all load enables.
    task automatic test_basic();
        bus.ex_valid   = 1'b1;
        bus.alu_res1   = 32'h1234_5678;
        bus.alu1_flags = 6'b001001;
        set_ld(6'b111111);
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1) begin $display("FAIL basic_valid got %b want 1", bus.wb_valid); n_fail++; end
        n_cmp++; if (bus.wb_res !== 32'h1234_5678) begin $display("FAIL basic_res got %h want 12345678", bus.wb_res); n_fail++; end
        n_cmp++; if (bus.eflags !== 32'h0000_0002) begin $display("FAIL basic_pre_eflags got %h want 2", bus.eflags); n_fail++; end
        n_cmp++; if (bus.CF_fwd !== 1'b1) begin $display("FAIL basic_cf_fwd got %b want 1", bus.CF_fwd); n_fail++; end
        idle_inputs();
        tick();
        n_cmp++; if (bus.eflags !== 32'h0000_0043) begin $display("FAIL basic_eflags got %h want 43", bus.eflags); n_fail++; end
        n_cmp++; if (bus.retire_cnt !== 16'd1) begin $display("FAIL basic_retire got %0d want 1", bus.retire_cnt); n_fail++; end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin $display("FAIL basic_clear got %b want 0", bus.wb_valid); n_fail++; end
        n_cmp++; if (bus.wb_res !== 32'h1234_5678) begin $display("FAIL basic_res_hold got %h want 12345678", bus.wb_res); n_fail++; end
    endtask

    // CMPS source selected; only SF may change.
    task automatic test_cmps_sel();
        bus.ex_valid   = 1'b1;
        bus.cmps_sel   = 1'b1;
        bus.cmps_flags = 6'b010000;
        bus.alu1_flags = 6'b111111;
        set_ld(6'b010000);
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (bus.eflags !== 32'h0000_00C3) begin $display("FAIL cmps_eflags got %h want c3", bus.eflags); n_fail++; end
        n_cmp++; if (bus.retire_cnt !== 16'd2) begin $display("FAIL cmps_retire got %0d want 2", bus.retire_cnt); n_fail++; end
    endtask

    // DF load and DF forwarding; the alu flags are ignored with no ld bits.
    task automatic test_df();
        bus.ex_valid   = 1'b1;
        bus.alu1_flags = 6'b111111;
        bus.ld_df      = 1'b1;
        bus.df_val_ex  = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (bus.DF_fwd !== 1'b1) begin $display("FAIL df_fwd got %b want 1", bus.DF_fwd); n_fail++; end
        n_cmp++; if (bus.eflags[10] !== 1'b0) begin $display("FAIL df_pre got %b want 0", bus.eflags[10]); n_fail++; end
        tick();
        n_cmp++; if (bus.eflags !== 32'h0000_04C3) begin $display("FAIL df_eflags got %h want 4c3", bus.eflags); n_fail++; end
        n_cmp++; if (bus.retire_cnt !== 16'd3) begin $display("FAIL df_retire got %0d want 3", bus.retire_cnt); n_fail++; end
    endtask

    // Entry A (sets AF) stalls 3 cycles while entry B (clears CF) waits.
    task automatic test_stall();
        bus.ex_valid   = 1'b1;
        bus.alu_res1   = 32'hAAAA_AAAA;
        bus.alu1_flags = 6'b000100;
        set_ld(6'b000100);
        tick();
        bus.wb_stall   = 1'b1;
        bus.alu_res1   = 32'hBBBB_BBBB;
        bus.alu1_flags = 6'b000000;
        set_ld(6'b000001);
        #1;
        n_cmp++; if (bus.ex_ready !== 1'b0) begin $display("FAIL stall_ready got %b want 0", bus.ex_ready); n_fail++; end
        n_cmp++; if (bus.AF_fwd !== 1'b1) begin $display("FAIL stall_af_fwd got %b want 1", bus.AF_fwd); n_fail++; end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_res !== 32'hAAAA_AAAA) begin $display("FAIL stall_hold%0d got %b/%h want 1/aaaaaaaa", i, bus.wb_valid, bus.wb_res); n_fail++; end
            n_cmp++; if (bus.eflags !== 32'h0000_04C3 || bus.retire_cnt !== 16'd3) begin $display("FAIL stall_arch%0d got %h/%0d want 4c3/3", i, bus.eflags, bus.retire_cnt); n_fail++; end
            n_cmp++; if (bus.ex_ready !== 1'b0) begin $display("FAIL stall_ready%0d got %b want 0", i, bus.ex_ready); n_fail++; end
        end
        bus.wb_stall = 1'b0;
        #1;
        n_cmp++; if (bus.ex_ready !== 1'b1) begin $display("FAIL stall_release_ready got %b want 1", bus.ex_ready); n_fail++; end
        tick();
        n_cmp++; if (bus.eflags !== 32'h0000_04D3) begin $display("FAIL stall_commit_eflags got %h want 4d3", bus.eflags); n_fail++; end
        n_cmp++; if (bus.retire_cnt !== 16'd4) begin $display("FAIL stall_commit_retire got %0d want 4", bus.retire_cnt); n_fail++; end
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_res !== 32'hBBBB_BBBB) begin $display("FAIL b2b_capture got %b/%h want 1/bbbbbbbb", bus.wb_valid, bus.wb_res); n_fail++; end
        n_cmp++; if (bus.CF_fwd !== 1'b0) begin $display("FAIL b2b_cf_fwd got %b want 0", bus.CF_fwd); n_fail++; end
        idle_inputs();
        tick();
        n_cmp++; if (bus.eflags !== 32'h0000_04D2) begin $display("FAIL b2b_eflags got %h want 4d2", bus.eflags); n_fail++; end
        n_cmp++; if (bus.retire_cnt !== 16'd5) begin $display("FAIL b2b_retire got %0d want 5", bus.retire_cnt); n_fail++; end
    endtask

    // CF forwarded before commit, then the entry is flushed.
    task automatic test_fwd_flush();
        bus.ex_valid   = 1'b1;
        bus.alu_res1   = 32'hC0DE_0001;
        bus.alu1_flags = 6'b000001;
        set_ld(6'b000001);
        tick();
        bus.ex_valid = 1'b0;
        bus.wb_stall = 1'b1;
        #1;
        n_cmp++; if (bus.CF_fwd !== 1'b1 || bus.eflags[0] !== 1'b0) begin $display("FAIL fwd_cf got %b/%b want 1/0", bus.CF_fwd, bus.eflags[0]); n_fail++; end
        bus.flush      = 1'b1;
        bus.ex_valid   = 1'b1;
        bus.alu_res1   = 32'hFFFF_0000;
        set_ld(6'b111111);
        #1;
        n_cmp++; if (bus.ex_ready !== 1'b0) begin $display("FAIL flush_ready got %b want 0", bus.ex_ready); n_fail++; end
        n_cmp++; if (bus.CF_fwd !== 1'b1) begin $display("FAIL flush_cf_fwd got %b want 1", bus.CF_fwd); n_fail++; end
        tick();
        idle_inputs();
        n_cmp++; if (bus.wb_valid !== 1'b0) begin $display("FAIL flush_valid got %b want 0", bus.wb_valid); n_fail++; end
        n_cmp++; if (bus.eflags !== 32'h0000_04D2 || bus.retire_cnt !== 16'd5) begin $display("FAIL flush_arch got %h/%0d want 4d2/5", bus.eflags, bus.retire_cnt); n_fail++; end
        n_cmp++; if (bus.wb_res !== 32'hC0DE_0001) begin $display("FAIL flush_no_capture got %h want c0de0001", bus.wb_res); n_fail++; end
        n_cmp++; if (bus.CF_fwd !== 1'b0) begin $display("FAIL flush_cf_after got %b want 0", bus.CF_fwd); n_fail++; end
    endtask

    // Async reset drops a pending entry; capture works on the first edge after.
    task automatic test_reset_mid();
        bus.ex_valid   = 1'b1;
        bus.alu_res1   = 32'h5555_5555;
        bus.alu1_flags = 6'b111111;
        set_ld(6'b111111);
        tick();
        idle_inputs();
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.wb_valid !== 1'b0 || bus.wb_res !== 32'h0) begin $display("FAIL rstmid_entry got %b/%h want 0/0", bus.wb_valid, bus.wb_res); n_fail++; end
        n_cmp++; if (bus.eflags !== 32'h0000_0002 || bus.retire_cnt !== 16'h0) begin $display("FAIL rstmid_arch got %h/%0d want 2/0", bus.eflags, bus.retire_cnt); n_fail++; end
        tick();
        bus.ex_valid   = 1'b1;
        bus.alu_res1   = 32'h0000_0077;
        bus.alu1_flags = 6'b000010;
        set_ld(6'b000010);
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_res !== 32'h77) begin $display("FAIL first_capture got %b/%h want 1/77", bus.wb_valid, bus.wb_res); n_fail++; end
        idle_inputs();
        tick();
        n_cmp++; if (bus.eflags !== 32'h0000_0006 || bus.retire_cnt !== 16'd1) begin $display("FAIL first_commit got %h/%0d want 6/1", bus.eflags, bus.retire_cnt); n_fail++; end
    endtask

    // Streaming entries with no load bits: one commit per cycle up to wrap.
    task automatic test_wrap();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        bus.ex_valid = 1'b1;
        repeat (65536) tick();
        n_cmp++; if (bus.retire_cnt !== 16'hFFFF || bus.wb_valid !== 1'b1) begin $display("FAIL wrap_pre got %h/%b want ffff/1", bus.retire_cnt, bus.wb_valid); n_fail++; end
        bus.ex_valid = 1'b0;
        tick();
        n_cmp++; if (bus.retire_cnt !== 16'h0000) begin $display("FAIL wrap_cnt got %h want 0000", bus.retire_cnt); n_fail++; end
        n_cmp++; if (bus.eflags !== 32'h0000_0002) begin $display("FAIL wrap_eflags got %h want 2", bus.eflags); n_fail++; end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        tick();
        test_basic();
        test_cmps_sel();
        test_df();
        test_stall();
        test_fwd_flush();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
